// File: rtl/mips_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mips_ctrl_pkg
//
// Purpose : Shared constants for the multicycle MIPS control path. Holds the
//           opcode values decoded by the main control FSM, the 3-bit ALUOp
//           encodings consumed by ALUControl, and the main-control state
//           encodings.
//
// Ports   : none (package).
//
// Config  : MC_BNE_EN -- when defined, OP_BNE is a legal opcode in the main
//           control FSM. The constant is always present here.
//------------------------------------------------------------------------------
package mips_ctrl_pkg;

   // Width of the main-control state register (13 encodings used).
   localparam int STATE_W = 4;

   // Opcode field IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALUOp encodings shared with ALUControl
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [2:0] ALUOP_AND   = 3'b011;
   localparam logic [2:0] ALUOP_OR    = 3'b110;
   localparam logic [2:0] ALUOP_SLT   = 3'b111;

   // Main control states; encodings 13..15 are unreachable.
   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_I_EXEC   = 4'd11,
      S_I_WB     = 4'd12
   } state_t;

endpackage

// File: rtl/multicycle_main_control.sv
//------------------------------------------------------------------------------
// multicycle_main_control
//
// Purpose : Main control FSM of the multicycle MIPS datapath. Steps each
//           instruction through fetch/decode/execute/memory/writeback and
//           drives every datapath enable and mux select plus the ALUOp field
//           handed to ALUControl. Moore outputs decoded from the state
//           register; the stable IR opcode is additionally used in DECODE
//           (next state, IllegalOp), I_EXEC (ALUOp, ZeroExt) and BRANCH
//           (BranchNe, feature only).
//
// Ports   : clk, rst_n (async active-low) ; opcode = IR[31:26]
//           PCWrite, PCWriteCond, BranchNe, PCSource[1:0] -- PC update
//           IorD, MemRead, MemWrite, IRWrite              -- memory / IR
//           MemtoReg, RegDst, RegWrite                    -- register file
//           ALUSrcA, ALUSrcB[1:0], ZeroExt, ALUOp[2:0]    -- ALU operands/op
//           InstrDone  -- final state of each instruction
//           IllegalOp  -- one-cycle pulse in DECODE for unsupported opcode
//
// Config  : MC_BNE_EN -- when defined, bne (000101) shares the BRANCH state
//           with beq and raises BranchNe there. When undefined, BranchNe is
//           tied low and 000101 is treated as an illegal opcode.
//------------------------------------------------------------------------------
module multicycle_main_control
   import mips_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       BranchNe,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ZeroExt,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
   output logic       InstrDone,
   output logic       IllegalOp
);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;

   // State register. Reset aborts any instruction in flight and parks the
   // machine in IDLE, which zeroes every output without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode. Every output defaults to 0 so each state
   // only lists what it asserts; unused encodings fall back to IDLE.
   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ZeroExt     = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = ALUOP_ADD;
      InstrDone   = 1'b0;
      IllegalOp   = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         // Read the instruction and compute PC+4 in the same cycle.
         S_FETCH: begin
            MemRead  = 1'b1;
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            ALUSrcB  = 2'b01;
            ALUOp    = ALUOP_ADD;
            PCSource = 2'b00;
            state_d  = S_DECODE;
         end

         // Speculatively compute the branch target while decoding.
         S_DECODE: begin
            ALUSrcB = 2'b11;
            ALUOp   = ALUOP_ADD;
            case (opcode)
               OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
               OP_RTYPE:                          state_d = S_R_EXEC;
               OP_BEQ:                            state_d = S_BRANCH;
`ifdef MC_BNE_EN
               OP_BNE:                            state_d = S_BRANCH;
`endif
               OP_J:                              state_d = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
               default: begin
                  IllegalOp = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end

         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = ALUOP_ADD;
            state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            state_d = S_MEM_WB;
         end

         S_MEM_WB: begin
            RegWrite  = 1'b1;
            MemtoReg  = 1'b1;
            InstrDone = 1'b1;
            state_d   = S_FETCH;
         end

         S_MEM_WR: begin
            MemWrite  = 1'b1;
            IorD      = 1'b1;
            InstrDone = 1'b1;
            state_d   = S_FETCH;
         end

         S_R_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b00;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_R_WB;
         end

         S_R_WB: begin
            RegDst    = 1'b1;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
            state_d   = S_FETCH;
         end

         // Compare A and B by subtraction; PC takes the target computed in
         // DECODE only if the datapath's branch condition holds.
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUSrcB     = 2'b00;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            InstrDone   = 1'b1;
`ifdef MC_BNE_EN
            BranchNe    = (opcode == OP_BNE);
`endif
            state_d     = S_FETCH;
         end

         S_JUMP: begin
            PCWrite   = 1'b1;
            PCSource  = 2'b10;
            InstrDone = 1'b1;
            state_d   = S_FETCH;
         end

         // ALU operation follows the immediate opcode; logical immediates
         // use a zero-extended operand.
         S_I_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_ANDI: begin
                  ALUOp   = ALUOP_AND;
                  ZeroExt = 1'b1;
               end
               OP_ORI: begin
                  ALUOp   = ALUOP_OR;
                  ZeroExt = 1'b1;
               end
               OP_SLTI: ALUOp = ALUOP_SLT;
               default: ALUOp = ALUOP_ADD;
            endcase
            state_d = S_I_WB;
         end

         S_I_WB: begin
            RegWrite  = 1'b1;
            RegDst    = 1'b0;
            MemtoReg  = 1'b0;
            InstrDone = 1'b1;
            state_d   = S_FETCH;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_main_control.sv
//------------------------------------------------------------------------------
// tb_multicycle_main_control
//
// Purpose : Self-checking bench for multicycle_main_control. A per-instruction
//           timeline model predicts the control word for every cycle of each
//           issued instruction; one compare process checks the DUT against
//           it on every falling edge, and directed literal checks pin the
//           model. Honours MC_BNE_EN the same way as the design.
//
// Ports   : none (top-level bench).
//------------------------------------------------------------------------------
module tb_multicycle_main_control;
   import mips_ctrl_pkg::*;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       branchNe;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memtoReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       zeroExt;
      logic [1:0] pcSource;
      logic [2:0] aluOp;
      logic       instrDone;
      logic       illegalOp;
   } ctl_t;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
   logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt;
   logic       InstrDone, IllegalOp;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;

   ctl_t dutVec;
   ctl_t expQ[$];
   ctl_t obs[8];
   int   checks   = 0;
   int   failures = 0;

   multicycle_main_control #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt),
      .PCSource(PCSource), .ALUOp(ALUOp), .InstrDone(InstrDone),
      .IllegalOp(IllegalOp)
   );

   assign dutVec = '{PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
                     IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                     ZeroExt, PCSource, ALUOp, InstrDone, IllegalOp};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Is the opcode one the controller must execute?
   function automatic bit isLegal(input logic [5:0] op);
      bit ok;
      ok = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000) ||
           (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001010);
`ifdef MC_BNE_EN
      if (op == 6'b000101) ok = 1'b1;
`endif
      return ok;
   endfunction

   // Instruction latency from fetch to final cycle inclusive.
   function automatic int modelLen(input logic [5:0] op);
      if (!isLegal(op))                          return 2;
      if (op == 6'b100011)                       return 5;
      if (op == 6'b000100 || op == 6'b000101 ||
          op == 6'b000010)                       return 3;
      return 4;
   endfunction

   // Control word expected in cycle 'step' (0 = fetch) of instruction 'op'.
   function automatic ctl_t modelOut(input logic [5:0] op, input int step);
      ctl_t c;
      int   last;
      c    = '0;
      last = modelLen(op) - 1;
      if (step == 0) begin
         c.memRead = 1; c.irWrite = 1; c.pcWrite = 1; c.aluSrcB = 2'b01;
      end else if (step == 1) begin
         c.aluSrcB   = 2'b11;
         c.illegalOp = !isLegal(op);
      end else if (op == 6'b100011 || op == 6'b101011) begin
         if (step == 2) begin
            c.aluSrcA = 1; c.aluSrcB = 2'b10;
         end else if (op == 6'b101011) begin
            c.memWrite = 1; c.iorD = 1;
         end else if (step == 3) begin
            c.memRead = 1; c.iorD = 1;
         end else begin
            c.regWrite = 1; c.memtoReg = 1;
         end
      end else if (op == 6'b000000) begin
         if (step == 2) c.aluOp = 3'b010;
         if (step == 2) c.aluSrcA = 1;
         if (step == 3) begin c.regDst = 1; c.regWrite = 1; end
      end else if (op == 6'b000100 || op == 6'b000101) begin
         c.aluSrcA = 1; c.aluOp = 3'b001; c.pcWriteCond = 1;
         c.pcSource = 2'b01; c.branchNe = (op == 6'b000101);
      end else if (op == 6'b000010) begin
         c.pcWrite = 1; c.pcSource = 2'b10;
      end else begin
         if (step == 2) begin
            c.aluSrcA = 1; c.aluSrcB = 2'b10;
            c.zeroExt = (op == 6'b001100) || (op == 6'b001101);
            case (op)
               6'b001100: c.aluOp = 3'b011;
               6'b001101: c.aluOp = 3'b110;
               6'b001010: c.aluOp = 3'b111;
               default:   c.aluOp = 3'b000;
            endcase
         end else begin
            c.regWrite = 1;
         end
      end
      c.instrDone = isLegal(op) && (step == last);
      return c;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual,
                  expected, $time);
      end
   endtask

   // Issue one instruction at its fetch cycle and record every cycle it
   // occupies so the caller can pin individual fields.
   task automatic applyStimulus(input logic [5:0] op);
      int n;
      @(posedge clk);
      #1;
      opcode = op;
      n = modelLen(op);
      for (int s = 0; s < n; s++) expQ.push_back(modelOut(op, s));
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         obs[s] = dutVec;
      end
   endtask

   // Compare process: one model entry per cycle while an instruction runs,
   // plus the memory/register-write exclusivity rule on every active cycle.
   always @(negedge clk) begin
      ctl_t e;
      if (rst_n && expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("model_cycle", 32'(dutVec), 32'(e));
      end
      if (rst_n) begin
         checkOutput("mem_reg_exclusive",
                     32'(int'(MemRead) + int'(MemWrite) + int'(RegWrite) > 1),
                     32'd0);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [5:0] iOps  [4];
   logic [2:0] iAlu  [4];
   logic       iZext [4];

   initial begin
      iOps  = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
      iAlu  = '{3'b000, 3'b011, 3'b110, 3'b111};
      iZext = '{1'b0, 1'b1, 1'b1, 1'b0};
      rst_n  = 1'b0;
      opcode = 6'b000000;

      // Reset held for three cycles: everything low.
      repeat (3) begin
         @(negedge clk);
         checkOutput("reset_zero", 32'(dutVec), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expQ.push_back('0);

      // lw
      applyStimulus(6'b100011);
      checkOutput("lw_fetch_word", {29'd0, obs[0].memRead, obs[0].irWrite,
                  obs[0].pcWrite}, 32'b111);
      checkOutput("lw_wb_write", {30'd0, obs[4].memtoReg, obs[4].regWrite},
                  32'b11);
      checkOutput("lw_done_only_last", {27'd0, obs[0].instrDone,
                  obs[1].instrDone, obs[2].instrDone, obs[3].instrDone,
                  obs[4].instrDone}, 32'b00001);

      // R-type then sw back to back
      applyStimulus(6'b000000);
      checkOutput("r_exec_aluop", 32'(obs[2].aluOp), 32'b010);
      checkOutput("r_wb_regdst", 32'(obs[3].regDst), 32'd1);
      applyStimulus(6'b101011);
      checkOutput("sw_memwr", {30'd0, obs[3].memWrite, obs[3].iorD}, 32'b11);

      // I-type sweep
      for (int i = 0; i < 4; i++) begin
         applyStimulus(iOps[i]);
         checkOutput("itype_aluop", 32'(obs[2].aluOp), 32'(iAlu[i]));
         checkOutput("itype_zeroext", 32'(obs[2].zeroExt), 32'(iZext[i]));
      end

      // beq, bne, j, illegal, then a normal instruction after the illegal one
      applyStimulus(6'b000100);
      checkOutput("beq_branch", {26'd0, obs[2].aluOp, obs[2].pcWriteCond,
                  obs[2].pcSource}, 32'b001_1_01);
      applyStimulus(6'b000101);
`ifdef MC_BNE_EN
      checkOutput("bne_branchne", 32'(obs[2].branchNe), 32'd1);
`else
      checkOutput("bne_illegal", 32'(obs[1].illegalOp), 32'd1);
`endif
      applyStimulus(6'b000010);
      checkOutput("j_pc", {29'd0, obs[2].pcWrite, obs[2].pcSource}, 32'b1_10);
      applyStimulus(6'b111111);
      checkOutput("illegal_pulse", 32'(obs[1].illegalOp), 32'd1);
      applyStimulus(6'b001000);

      // Mid-instruction reset during the lw memory read.
      @(posedge clk);
      #1;
      opcode = 6'b100011;
      for (int s = 0; s < 3; s++) expQ.push_back(modelOut(6'b100011, s));
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("midrst_memrd", {30'd0, MemRead, IorD}, 32'b11);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_async_zero", 32'(dutVec), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      expQ.push_back('0);
      applyStimulus(6'b000000);

      @(negedge clk);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
